train_timer_bank: RTL

Bank of independent, parametrised down-counting timers for the train controller FSM.
- Each channel is loaded with a duration, counts down on a shared prescaled tick, and raises a level "expired" flag plus a one-cycle done pulse.
- Each channel runs one-shot or periodic (auto-reload).
- It replaces ad-hoc single-timer logic: the controller states (e.g. door open, station dwell, signal hold) each get a dedicated channel and a clean synchronous load/cancel interface.

---
 rtl/train_timer_pkg.sv | 9 +
 rtl/train_timer_channel.sv | 73 +++++++
 rtl/train_timer_bank.sv | 66 ++++++
 3 files changed

// File: rtl/train_timer_pkg.sv
// Shared constants for the train controller timer bank.
package train_timer_pkg;

    localparam int TIMER_WIDTH = 19;

    localparam logic MODE_ONE_SHOT = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/train_timer_channel.sv
// One down-counting timer channel: one-shot or auto-reload, with level
// expired flag and a registered one-cycle done pulse.
module timer_channel
    import train_timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             periodic,
    input  logic             cancel,
    output logic             busy,
    output logic             expired,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] reload;
    logic             mode;
    logic             terminal;

    assign terminal = (count == WIDTH'(1));

    // Priority per edge: cancel, then load, then tick-driven decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            reload  <= '0;
            mode    <= MODE_ONE_SHOT;
            busy    <= 1'b0;
            expired <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                count   <= '0;
                busy    <= 1'b0;
                expired <= 1'b1;
            end else if (load) begin
                if (load_value != '0) begin
                    count   <= load_value;
                    reload  <= load_value;
                    mode    <= periodic;
                    busy    <= 1'b1;
                    expired <= 1'b0;
                end else begin
                    // A zero duration expires immediately and leaves the channel idle.
                    count   <= '0;
                    busy    <= 1'b0;
                    expired <= 1'b1;
                    done    <= 1'b1;
                end
            end else if (tick && busy) begin
                if (terminal) begin
                    done <= 1'b1;
                    if (mode == MODE_PERIODIC) begin
                        count <= reload;
                    end else begin
                        count   <= '0;
                        busy    <= 1'b0;
                        expired <= 1'b1;
                    end
                end else begin
                    count <= count - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/train_timer_bank.sv
// Bank of independent timer channels sharing one free-running prescaler;
// channel counts are packed side by side on the count bus.
module train_timer_bank
    import train_timer_pkg::*;
#(
    parameter int WIDTH    = TIMER_WIDTH,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [CHANNELS-1:0]       cancel,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       expired,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS*WIDTH-1:0] count
);

    logic tick;

    // The prescaler is never cleared by load, so first-tick latency varies by phase.
    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam int PW = $clog2(PRESCALE);
            logic [PW-1:0] presc;

            assign tick = (presc == PW'(PRESCALE - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    presc <= '0;
                end else if (tick) begin
                    presc <= '0;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end else begin : g_no_prescale
            assign tick = 1'b1;
        end
    endgenerate

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            timer_channel #(
                .WIDTH(WIDTH)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .tick      (tick),
                .load      (load[i]),
                .load_value(load_value),
                .periodic  (periodic[i]),
                .cancel    (cancel[i]),
                .busy      (busy[i]),
                .expired   (expired[i]),
                .done      (done[i]),
                .count     (count[i*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule
